codec_stream_ctrl: RTL and testbench

CODEC_STREAM_CTRL -- requirements
Module: codec_stream_ctrl

---
 rtl/codec_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_codec_stream_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_stream_ctrl.sv
// codec_stream_ctrl: moves one stereo sample pair per codec handshake from the
// codec input, through an external fixed-latency filter, to the codec output.
// Samples are passed bit-exact; the latched bypass flag selects the raw
// captured pair instead of the filter result for that one sample.
`timescale 1ns/1ps

module codec_stream_ctrl #(
  parameter int FILT_LAT = 1,
  parameter int W        = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         read_ready,
  input  logic [W-1:0] readdata_left,
  input  logic [W-1:0] readdata_right,
  output logic         read,
  input  logic         write_ready,
  output logic [W-1:0] writedata_left,
  output logic [W-1:0] writedata_right,
  output logic         write,
  output logic [W-1:0] filt_in_left,
  output logic [W-1:0] filt_in_right,
  output logic         filt_valid,
  input  logic [W-1:0] filt_out_left,
  input  logic [W-1:0] filt_out_right,
  input  logic         bypass,
  output logic [15:0]  sample_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT, WRITE} state_t;

  // FILT_LAT is limited to 1..15, so four bits cover the wait counter
  localparam logic [3:0] LAT = 4'(FILT_LAT);

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_hold_left;
  logic [W-1:0]  r_hold_right;
  logic          r_hold_bypass;
  logic [3:0]    r_wait_cnt;
  logic [W-1:0]  r_wd_left;
  logic [W-1:0]  r_wd_right;
  logic [15:0]   r_sample_count;
  logic          w_capture_en;
  logic          w_load_out;

  // The filter sees the holding registers directly; they only change on capture
  assign filt_in_left    = r_hold_left;
  assign filt_in_right   = r_hold_right;
  assign writedata_left  = r_wd_left;
  assign writedata_right = r_wd_right;
  assign sample_count    = r_sample_count;

  // State register; reset abandons any sample in flight
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and strobe decode; strobes are only ever high in one state each
  always_comb begin
    w_next_state = r_state;
    read         = 1'b0;
    filt_valid   = 1'b0;
    write        = 1'b0;
    w_capture_en = 1'b0;
    w_load_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_ready) begin
          w_capture_en = 1'b1;
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        read         = 1'b1;
        filt_valid   = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        // counter is loaded with FILT_LAT, so this is the last wait cycle
        if (r_wait_cnt <= 4'd1) begin
          w_load_out   = 1'b1;
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        write = write_ready;
        if (write_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Holding registers: input pair and bypass choice frozen for the whole sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_left   <= '0;
      r_hold_right  <= '0;
      r_hold_bypass <= 1'b0;
    end else if (w_capture_en) begin
      r_hold_left   <= readdata_left;
      r_hold_right  <= readdata_right;
      r_hold_bypass <= bypass;
    end
  end

  // Filter latency counter: loaded on capture, counts down through WAIT
  always_ff @(posedge clk) begin
    if (reset)                  r_wait_cnt <= '0;
    else if (r_state == CAPTURE) r_wait_cnt <= LAT;
    else if (r_state == WAIT)    r_wait_cnt <= r_wait_cnt - 4'd1;
  end

  // Output registers: stay stable from the last wait cycle until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_left  <= '0;
      r_wd_right <= '0;
    end else if (w_load_out) begin
      r_wd_left  <= r_hold_bypass ? r_hold_left  : filt_out_left;
      r_wd_right <= r_hold_bypass ? r_hold_right : filt_out_right;
    end
  end

  // Completed-write counter, free-running modulo 2^16
  always_ff @(posedge clk) begin
    if (reset)      r_sample_count <= '0;
    else if (write) r_sample_count <= r_sample_count + 16'd1;
  end

endmodule

// File: tb/tb_codec_stream_ctrl.sv
// tb_codec_stream_ctrl: directed bench for codec_stream_ctrl. Two instances
// share all inputs: one with FILT_LAT=1, one with FILT_LAT=3. Each has a
// filter model that returns input>>>3 only in the exact cycle FILT_LAT after
// filt_valid, and a junk pattern otherwise.
`timescale 1ns/1ps

module tb_codec_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_ready;
  logic        write_ready;
  logic        bypass;
  logic [23:0] rd_l;
  logic [23:0] rd_r;

  logic        rd1, wr1, fv1;
  logic [23:0] wd1_l, wd1_r, fi1_l, fi1_r, fo1_l, fo1_r;
  logic [15:0] sc1;
  logic        rd3, wr3, fv3;
  logic [23:0] wd3_l, wd3_r, fi3_l, fi3_r, fo3_l, fo3_r;
  logic [15:0] sc3;

  int checks   = 0;
  int failures = 0;
  int n_rd, n_wr, n_bad, n_wr1, n_wr3, n_rd3;

  always #5 clk = ~clk;

  codec_stream_ctrl #(.FILT_LAT(1), .W(24)) dut1 (
    .clk(clk), .reset(reset), .read_ready(read_ready),
    .readdata_left(rd_l), .readdata_right(rd_r), .read(rd1),
    .write_ready(write_ready), .writedata_left(wd1_l), .writedata_right(wd1_r),
    .write(wr1), .filt_in_left(fi1_l), .filt_in_right(fi1_r), .filt_valid(fv1),
    .filt_out_left(fo1_l), .filt_out_right(fo1_r), .bypass(bypass),
    .sample_count(sc1)
  );

  codec_stream_ctrl #(.FILT_LAT(3), .W(24)) dut3 (
    .clk(clk), .reset(reset), .read_ready(read_ready),
    .readdata_left(rd_l), .readdata_right(rd_r), .read(rd3),
    .write_ready(write_ready), .writedata_left(wd3_l), .writedata_right(wd3_r),
    .write(wr3), .filt_in_left(fi3_l), .filt_in_right(fi3_r), .filt_valid(fv3),
    .filt_out_left(fo3_l), .filt_out_right(fo3_r), .bypass(bypass),
    .sample_count(sc3)
  );

  // Filter models: result valid only when age equals the instance latency
  logic [4:0]  age1 = '0;
  logic [4:0]  age3 = '0;
  logic [23:0] pend1_l, pend1_r, pend3_l, pend3_r;

  always @(posedge clk) begin
    if (fv1) begin
      age1    <= 5'd1;
      pend1_l <= $signed(fi1_l) >>> 3;
      pend1_r <= $signed(fi1_r) >>> 3;
    end else if (age1 != 5'd0 && age1 < 5'd20) begin
      age1 <= age1 + 5'd1;
    end
  end

  always @(posedge clk) begin
    if (fv3) begin
      age3    <= 5'd1;
      pend3_l <= $signed(fi3_l) >>> 3;
      pend3_r <= $signed(fi3_r) >>> 3;
    end else if (age3 != 5'd0 && age3 < 5'd20) begin
      age3 <= age3 + 5'd1;
    end
  end

  assign fo1_l = (age1 == 5'd1) ? pend1_l : 24'hA5A5A5;
  assign fo1_r = (age1 == 5'd1) ? pend1_r : 24'h5A5A5A;
  assign fo3_l = (age3 == 5'd3) ? pend3_l : 24'hA5A5A5;
  assign fo3_r = (age3 == 5'd3) ? pend3_r : 24'h5A5A5A;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0; bypass = 1'b0;
    rd_l = '0; rd_r = '0;
    tick(2);
    chk("rst_count1", 32'(sc1), 32'h0);
    chk("rst_count3", 32'(sc3), 32'h0);
    chk("rst_wd1", 32'({wd1_l | wd1_r}), 32'h0);
    chk("rst_fi1", 32'({fi1_l | fi1_r}), 32'h0);
    chk("rst_strobes", 32'({rd1, wr1, fv1, rd3, wr3, fv3}), 32'h0);

    // Basic sample: cycle 1 IDLE, 2 CAPTURE, 3 WAIT, 4 WRITE for FILT_LAT=1
    rd_l = 24'h000010; rd_r = 24'hFFFFF0; read_ready = 1'b1; write_ready = 1'b1;
    tick(1);
    reset = 1'b0; #1;
    chk("c1_idle_strobes", 32'({rd1, fv1, wr1}), 32'h0);
    tick(1);
    chk("c2_read_fv", 32'({rd1, fv1, wr1}), 32'h6);
    chk("c2_filt_in_l", 32'(fi1_l), 32'h000010);
    chk("c2_filt_in_r", 32'(fi1_r), 32'hFFFFF0);
    chk("c2_read3", 32'(rd3), 32'h1);
    read_ready = 1'b0;
    tick(1);
    chk("c3_wait_strobes", 32'({rd1, fv1, wr1}), 32'h0);
    tick(1);
    chk("c4_write1", 32'(wr1), 32'h1);
    chk("c4_wd1_l", 32'(wd1_l), 32'h000002);
    chk("c4_wd1_r", 32'(wd1_r), 32'hFFFFFE);
    tick(1);
    chk("c5_count1", 32'(sc1), 32'h1);
    chk("c5_write1_off", 32'(wr1), 32'h0);
    tick(1);
    chk("c6_write3", 32'(wr3), 32'h1);
    chk("c6_wd3_l", 32'(wd3_l), 32'h000002);
    chk("c6_wd3_r", 32'(wd3_r), 32'hFFFFFE);
    tick(1);
    chk("c7_count3", 32'(sc3), 32'h1);

    // Write stall: read_ready stays high but must not be acknowledged
    rd_l = 24'h000040; rd_r = 24'h000100; read_ready = 1'b1; write_ready = 1'b0;
    tick(3);
    n_rd = 0; n_wr = 0; n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      n_rd += int'(rd1) + int'(rd3);
      n_wr += int'(wr1) + int'(wr3);
      if (wd1_l !== 24'h000008 || wd1_r !== 24'h000020) n_bad++;
      tick(1);
    end
    chk("stall_writes", 32'(n_wr), 32'h0);
    chk("stall_reads", 32'(n_rd), 32'h0);
    chk("stall_wd1_unstable", 32'(n_bad), 32'h0);
    write_ready = 1'b1; read_ready = 1'b0; #1;
    chk("stall_release_wr", 32'({wr1, wr3}), 32'h3);
    chk("stall_wd3_l", 32'(wd3_l), 32'h000008);
    tick(1);
    chk("stall_single_write", 32'({wr1, wr3}), 32'h0);
    chk("stall_count1", 32'(sc1), 32'h2);
    chk("stall_count3", 32'(sc3), 32'h2);

    // Bypass latched at capture; clearing it during WAIT must not matter
    bypass = 1'b1; rd_l = 24'h123456; rd_r = 24'h654321; read_ready = 1'b1;
    tick(1);
    read_ready = 1'b0;
    tick(1);
    bypass = 1'b0;
    tick(1);
    chk("byp_write1", 32'(wr1), 32'h1);
    chk("byp_wd1_l", 32'(wd1_l), 32'h123456);
    chk("byp_wd1_r", 32'(wd1_r), 32'h654321);
    tick(2);
    chk("byp_write3", 32'(wr3), 32'h1);
    chk("byp_wd3_l", 32'(wd3_l), 32'h123456);
    tick(1);
    chk("hold_filt_in1", 32'(fi1_l), 32'h123456);
    chk("hold_wd1", 32'(wd1_l), 32'h123456);
    chk("byp_count1", 32'(sc1), 32'h3);

    // Reset while both instances sit in WAIT
    rd_l = 24'h000080; rd_r = 24'hFFFF80; read_ready = 1'b1;
    tick(1);
    read_ready = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_strobes", 32'({rd1, wr1, fv1, rd3, wr3, fv3}), 32'h0);
    chk("mid_rst_count", 32'({sc1, sc3}), 32'h0);
    chk("mid_rst_wd1", 32'(wd1_l), 32'h0);
    reset = 1'b0; rd_l = 24'h000010; rd_r = 24'hFFFFF0; read_ready = 1'b1; #1;
    chk("post_rst_idle", 32'({rd1, wr1, fv1, rd3, wr3, fv3}), 32'h0);
    tick(1);
    read_ready = 1'b0;
    tick(2);
    chk("post_rst_write1", 32'(wr1), 32'h1);
    chk("post_rst_wd1_l", 32'(wd1_l), 32'h000002);
    tick(2);
    chk("post_rst_write3", 32'(wr3), 32'h1);
    chk("post_rst_wd3_r", 32'(wd3_r), 32'hFFFFFE);
    tick(1);
    chk("post_rst_count", 32'({sc1, sc3}), 32'h00010001);

    // Throughput: 60 cycles with both readies high
    read_ready = 1'b1; write_ready = 1'b1;
    n_wr1 = 0; n_wr3 = 0; n_rd3 = 0;
    for (int i = 0; i < 60; i++) begin
      n_wr1 += int'(wr1);
      n_wr3 += int'(wr3);
      n_rd3 += int'(rd3);
      tick(1);
    end
    read_ready = 1'b0;
    chk("tput_writes3", 32'(n_wr3), 32'd10);
    chk("tput_reads3", 32'(n_rd3), 32'd10);
    chk("tput_count3", 32'(sc3), 32'd11);
    chk("tput_writes1", 32'(n_wr1), 32'd15);
    chk("tput_count1", 32'(sc1), 32'd16);

    // Wrap: preload the counter to its maximum, then complete one sample
    force dut1.r_sample_count = 16'hFFFF;
    @(negedge clk);
    release dut1.r_sample_count;
    tick(1);
    read_ready = 1'b1;
    tick(1);
    read_ready = 1'b0;
    tick(2);
    chk("wrap_write1", 32'(wr1), 32'h1);
    tick(1);
    chk("wrap_count1", 32'(sc1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
